lpc_frame_sequencer: RTL and testbench
======================================

LPC_FRAME_SEQUENCER -- requirements
Module: lpc_frame_sequencer

Interface
REQ-001 Parameter FRAME_LEN, 160, samples per frame; also the residue words per frame.
REQ-002 Parameter ORDER, 10, LPC coefficients per frame; width of one-hot a_rsel.
REQ-003 Parameter TIMEOUT, 4096, maximum WAIT cycles before the error path is taken.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  audio sample offered.
REQ-007 in_ready  out  1  sequencer accepts sample.
REQ-008 in_data  in  16  signed audio sample.
REQ-009 out_valid  out  1  output word offered.
REQ-010 out_ready  in  1  downstream accepts word.
REQ-011 out_data  out  32  coefficient (raw) or residue (sign-extended).
REQ-012 out_type  out  1  0 = coefficient, 1 = residue.
REQ-013 out_last  out  1  final residue word of frame.
REQ-014 enc_x_wen / enc_x_waddr / enc_x_din  out  1/8/16  encoder sample write port.
REQ-015 enc_start  out  1  encoder start pulse.
REQ-016 enc_rready  in  1  encoder results valid.
REQ-017 enc_a_rsel / enc_a_dout  out/in  10/32  one-hot coefficient select; combinational read data.
REQ-018 enc_residue_raddr / enc_residue_dout  out/in  8/16  residue address; combinational read data.
REQ-019 err  out  1  one-cycle pulse on WAIT timeout.

Function
REQ-020 States SHALL be LOAD, START, WAIT, EMIT_A, EMIT_R; there is no other state.
REQ-021 LOAD: in_ready=1; each in_valid&&in_ready SHALL drive enc_x_wen=1, enc_x_waddr=sample index, enc_x_din=in_data in the same cycle, then increment the index.
REQ-022 The index SHALL count 0..FRAME_LEN-1; acceptance of index FRAME_LEN-1 SHALL clear the index and move to START.
REQ-023 in_ready SHALL be 0 in every state except LOAD; in_valid outside LOAD is ignored and no write occurs.
REQ-024 START: enc_start=1 for exactly one cycle, then WAIT.
REQ-025 WAIT: enc_rready SHALL be ignored for the first 2 cycles (guard); from the third WAIT cycle, enc_rready=1 moves to EMIT_A.
REQ-026 WAIT counter reaching TIMEOUT with enc_rready still 0 SHALL pulse err for one cycle, discard the frame and return to LOAD.
REQ-027 EMIT_A: out_valid=1, out_type=0, enc_a_rsel=1<<k, out_data=enc_a_dout for k=0..ORDER-1; k advances only on out_valid&&out_ready.
REQ-028 Acceptance of k=ORDER-1 SHALL move to EMIT_R with residue index 0.
REQ-029 EMIT_R: out_valid=1, out_type=1, enc_residue_raddr=j, out_data={{16{enc_residue_dout[15]}},enc_residue_dout}; j advances only on a handshake.
REQ-030 out_last SHALL be 1 only in EMIT_R with j=FRAME_LEN-1; acceptance of that word SHALL return to LOAD.
REQ-031 While out_valid=1 and out_ready=0, out_data, out_type, out_last and the read address SHALL stay stable.
REQ-032 Outside EMIT_A, out_valid=0 and enc_a_rsel=0; outside EMIT_R, enc_residue_raddr=0.
REQ-033 enc_x_wen SHALL be 0 in every state except LOAD, and enc_start SHALL be 0 in every state except START.
REQ-034 Counters SHALL be exactly wide enough for their ranges (8-bit sample/residue index, 4-bit k, 13-bit timeout); they SHALL never wrap past their terminal values.

Reset
REQ-035 Reset SHALL put the block in LOAD with all indices and the timeout counter at 0, and in the same cycle force out_valid, err, enc_start and enc_x_wen to 0 and in_ready to 1.
REQ-036 Reset asserted in any state SHALL abort the frame in that cycle; a partial frame is discarded and no enc_start is issued.

Verification
REQ-037 Stream 160 samples 0..159 with in_valid held high -> 160 writes at addresses 0..159, one enc_start 1 cycle after the last write.
REQ-038 Hold enc_rready=1 throughout -> no transition to EMIT_A during the 2 guard cycles; EMIT_A entered on the third WAIT cycle.
REQ-039 Drive a_dout=0x1000_0000+k and residue=-j; out_ready always 1 -> 10 words type 0, then 160 words type 1 with 0xFFFF_FFFF.. values, out_last only on word 170.
REQ-040 Toggle out_ready 1/0 every cycle in EMIT_R -> no word lost or duplicated; data stays stable while stalled.
REQ-041 Never assert enc_rready -> err pulses once at WAIT cycle 4096, state LOAD, in_ready=1.
REQ-042 Assert reset after sample 77 and again mid-EMIT_R -> LOAD, index 0, out_valid=0 next cycle; following full frame processes normally.

Source files
------------

// File: rtl/lpc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_frame_sequencer
//  Description : Frame sequencer wrapped around an LPC encoder core. Buffers
//                FRAME_LEN audio samples into the encoder, starts it, waits
//                for its results (bounded by TIMEOUT), then streams ORDER raw
//                coefficients followed by FRAME_LEN sign-extended residues.
//  Ports       : clk/reset         - clock, synchronous active-high reset
//                in_*              - sample input stream (valid/ready)
//                out_*             - word output stream (valid/ready) with
//                                    type (0 coef / 1 residue) and last flag
//                enc_x_*           - encoder sample write port
//                enc_start         - encoder start pulse
//                enc_rready        - encoder results available
//                enc_a_rsel/dout   - one-hot coefficient select / read data
//                enc_residue_*     - residue address / read data
//                err               - one-cycle pulse on encoder timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module lpc_frame_sequencer #(
    parameter int FRAME_LEN = 160,
    parameter int ORDER     = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic                         out_type,
    output logic                         out_last,
    output logic                         enc_x_wen,
    output logic [$clog2(FRAME_LEN)-1:0] enc_x_waddr,
    output logic [15:0]                  enc_x_din,
    output logic                         enc_start,
    input  logic                         enc_rready,
    output logic [ORDER-1:0]             enc_a_rsel,
    input  logic [31:0]                  enc_a_dout,
    output logic [$clog2(FRAME_LEN)-1:0] enc_residue_raddr,
    input  logic [15:0]                  enc_residue_dout,
    output logic                         err
);

    localparam int c_idx_w = $clog2(FRAME_LEN);
    localparam int c_k_w   = $clog2(ORDER);
    localparam int c_to_w  = $clog2(TIMEOUT + 1);

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(FRAME_LEN - 1);
    localparam logic [c_k_w-1:0]   c_k_last   = c_k_w'(ORDER - 1);
    localparam logic [c_to_w-1:0]  c_to_limit = c_to_w'(TIMEOUT);
    // The encoder needs two cycles after start before enc_rready is meaningful.
    localparam logic [c_to_w-1:0]  c_guard    = c_to_w'(2);
    localparam logic [ORDER-1:0]   c_rsel_one = ORDER'(1);

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EMIT_A = 3'd3,
        ST_EMIT_R = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_x_idx;
    logic [c_idx_w-1:0]   r_r_idx;
    logic [c_k_w-1:0]     r_k;
    logic [c_to_w-1:0]    r_wait_cnt;
    logic [c_to_w-1:0]    w_wait_inc;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_timeout;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and handshake qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_fire   = 1'b0;
        w_out_fire  = 1'b0;
        w_timeout   = 1'b0;
        // r_wait_cnt holds (WAIT cycle number - 1), so the increment is the
        // current WAIT cycle number.
        w_wait_inc  = r_wait_cnt + 1'b1;
        case (r_state)
            ST_LOAD: begin
                w_in_fire = in_valid;
                if (in_valid && (r_x_idx == c_idx_last)) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if ((r_wait_cnt >= c_guard) && enc_rready) begin
                    w_state_nxt = ST_EMIT_A;
                end else if (w_wait_inc == c_to_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_EMIT_A: begin
                w_out_fire = out_ready;
                if (out_ready && (r_k == c_k_last)) begin
                    w_state_nxt = ST_EMIT_R;
                end
            end
            ST_EMIT_R: begin
                w_out_fire = out_ready;
                if (out_ready && (r_r_idx == c_idx_last)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Index and timeout counters; each stops at its terminal value
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_idx    <= '0;
            r_r_idx    <= '0;
            r_k        <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_in_fire) begin
                r_x_idx <= (r_x_idx == c_idx_last) ? '0 : r_x_idx + 1'b1;
            end
            r_wait_cnt <= ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) ? w_wait_inc : '0;
            if ((r_state == ST_EMIT_A) && w_out_fire) begin
                r_k <= (r_k == c_k_last) ? '0 : r_k + 1'b1;
            end
            if ((r_state == ST_EMIT_R) && w_out_fire) begin
                r_r_idx <= (r_r_idx == c_idx_last) ? '0 : r_r_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset overrides the control outputs in the cycle it is
    // asserted so an aborted frame produces no stray write/start/word.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready          = (r_state == ST_LOAD) || reset;
        enc_x_wen         = w_in_fire && !reset;
        enc_x_waddr       = r_x_idx;
        enc_x_din         = in_data;
        enc_start         = (r_state == ST_START) && !reset;
        err               = w_timeout && !reset;
        out_valid         = ((r_state == ST_EMIT_A) || (r_state == ST_EMIT_R)) && !reset;
        out_type          = (r_state == ST_EMIT_R);
        out_last          = (r_state == ST_EMIT_R) && (r_r_idx == c_idx_last);
        enc_a_rsel        = (r_state == ST_EMIT_A) ? (c_rsel_one << r_k) : '0;
        enc_residue_raddr = (r_state == ST_EMIT_R) ? r_r_idx : '0;
        out_data          = (r_state == ST_EMIT_R)
                          ? {{16{enc_residue_dout[15]}}, enc_residue_dout}
                          : enc_a_dout;
    end

endmodule
`default_nettype wire

// File: tb/tb_lpc_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpc_frame_sequencer
//  Description : Scoreboard bench for lpc_frame_sequencer with a behavioural
//                encoder model (coefficient = base + k, residue = -sample).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lpc_frame_sequencer;

    localparam int FRAME_LEN = 160;
    localparam int ORDER     = 10;
    localparam int TIMEOUT   = 4096;
    localparam logic [ORDER-1:0] ONEHOT0 = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_type;
    logic        out_last;
    logic        enc_x_wen;
    logic [7:0]  enc_x_waddr;
    logic [15:0] enc_x_din;
    logic        enc_start;
    logic        enc_rready;
    logic [ORDER-1:0] enc_a_rsel;
    logic [31:0] enc_a_dout;
    logic [7:0]  enc_residue_raddr;
    logic [15:0] enc_residue_dout;
    logic        err;

    always #5 clk = ~clk;

    lpc_frame_sequencer #(
        .FRAME_LEN(FRAME_LEN), .ORDER(ORDER), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_type(out_type), .out_last(out_last),
        .enc_x_wen(enc_x_wen), .enc_x_waddr(enc_x_waddr), .enc_x_din(enc_x_din),
        .enc_start(enc_start), .enc_rready(enc_rready),
        .enc_a_rsel(enc_a_rsel), .enc_a_dout(enc_a_dout),
        .enc_residue_raddr(enc_residue_raddr), .enc_residue_dout(enc_residue_dout),
        .err(err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        typ;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Encoder model
    // ------------------------------------------------------------------
    logic [15:0] x_mem [FRAME_LEN];
    logic [31:0] coef_base;

    always @(posedge clk)
        if (enc_x_wen && (enc_x_waddr < FRAME_LEN)) x_mem[enc_x_waddr] <= enc_x_din;

    always_comb begin
        enc_a_dout = 32'hDEAD_BEEF;
        for (int i = 0; i < ORDER; i++)
            if (enc_a_rsel == (ONEHOT0 << i)) enc_a_dout = coef_base + 32'(i);
        enc_residue_dout = 16'h0;
        if (enc_residue_raddr < FRAME_LEN) enc_residue_dout = 16'h0 - x_mem[enc_residue_raddr];
    end

    int  enc_delay = 0;
    bit  enc_never = 1'b0;
    int  starts_seen = 0;
    int  start_cyc = 0;
    int  last_wr_cyc = -100;

    // enc_rready rises enc_delay cycles after the start cycle and stays high
    // until the first output word. Expected latency start->first word is
    // max(3, delay) + 1: the first two WAIT cycles ignore enc_rready.
    initial begin
        int  rdy_cd;
        int  exp_lat;
        bit  lat_pending;
        rdy_cd = -1; exp_lat = 0; lat_pending = 1'b0;
        enc_rready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rdy_cd = -1; enc_rready = 1'b0; lat_pending = 1'b0;
            end else begin
                if (enc_start) begin
                    starts_seen++;
                    start_cyc = cyc;
                    check("start_after_last_write", 64'(cyc - last_wr_cyc), 64'd1);
                    lat_pending = !enc_never;
                    exp_lat = ((enc_delay > 3) ? enc_delay : 3) + 1;
                    if (!enc_never) rdy_cd = enc_delay;
                end
                if (out_valid) begin
                    if (lat_pending) begin
                        check("ready_to_first_word", 64'(cyc - start_cyc), 64'(exp_lat));
                        lat_pending = 1'b0;
                    end
                    enc_rready = 1'b0; rdy_cd = -1;
                end
                if (rdy_cd == 0) begin
                    enc_rready = 1'b1; rdy_cd = -1;
                end else if (rdy_cd > 0) begin
                    rdy_cd--;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Downstream ready driver: 0 = always, 1 = toggle in residues, 2 = random
    // ------------------------------------------------------------------
    int rdy_mode = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       out_ready = (out_valid && out_type) ? !out_ready : 1'b1;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Monitor: write port, output words, stall stability
    // ------------------------------------------------------------------
    initial begin
        word_t w;
        word_t snap;
        bit    hold;
        int    wr_idx;
        hold = 1'b0; wr_idx = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0; wr_idx = 0;
            end else begin
                if (hold && out_valid)
                    check("stall_stable", {out_data, out_type, out_last, enc_residue_raddr}, {snap, enc_residue_raddr});
                hold = 1'b0;
                if (enc_x_wen) begin
                    check("wr_addr", enc_x_waddr, wr_idx);
                    check("wr_data", enc_x_din, in_data);
                    if (enc_x_waddr == 8'(FRAME_LEN - 1)) last_wr_cyc = cyc;
                    wr_idx = (wr_idx == FRAME_LEN - 1) ? 0 : wr_idx + 1;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_word: actual=%0h required=none", out_data);
                    end else begin
                        w = exp_q.pop_front();
                        check("out_word", {out_data, out_type, out_last}, w);
                    end
                end else if (out_valid) begin
                    hold = 1'b1;
                    snap = {out_data, out_type, out_last};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic send_frame(input int n, input bit ramp, input bit gaps,
                              input logic [31:0] base, input bit expect_out);
        logic [15:0] s [FRAME_LEN];
        logic [15:0] r;
        word_t       w;
        bit          acc;
        for (int i = 0; i < FRAME_LEN; i++) s[i] = ramp ? 16'(i) : 16'($urandom);
        coef_base = base;
        if (expect_out) begin
            for (int k = 0; k < ORDER; k++) begin
                w.data = base + 32'(k); w.typ = 1'b0; w.last = 1'b0;
                exp_q.push_back(w);
            end
            for (int j = 0; j < FRAME_LEN; j++) begin
                r = 16'h0 - s[j];
                w.data = {{16{r[15]}}, r}; w.typ = 1'b1; w.last = (j == FRAME_LEN - 1);
                exp_q.push_back(w);
            end
        end
        for (int i = 0; i < n; i++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0; in_data = 16'($urandom);
                    @(posedge clk); #1;
                end
            in_valid = 1'b1; in_data = s[i];
            acc = 1'b0;
            for (int b = 0; b < 20000 && !acc; b++) begin
                @(negedge clk); acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                n_cmp++; n_fail++;
                $display("FAIL accept_timeout: actual=no_accept required=accept sample %0d", i);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int b = 0; b < 20000 && exp_q.size() != 0; b++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_enc_start", enc_start, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int  sc;
        bit  found;
        reset = 1'b1; in_valid = 1'b1; in_data = 16'h1234; coef_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_wen", enc_x_wen, 1'b0);
        check("reset_start", enc_start, 1'b0);
        check("reset_err", err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle_rsel", enc_a_rsel, '0);
        check("idle_raddr", enc_residue_raddr, 8'd0);
        @(posedge clk); #1;

        // Ramp frame, encoder ready immediately, no back-pressure.
        enc_delay = 0; rdy_mode = 0;
        send_frame(FRAME_LEN, 1'b1, 1'b0, 32'h1000_0000, 1'b1);
        wait_drain();
        check("one_start_per_frame", 64'(starts_seen), 64'd1);

        // Random frames with varied encoder delay and back-pressure.
        for (int f = 0; f < 4; f++) begin
            enc_delay = $urandom_range(0, 8);
            rdy_mode  = f % 3;
            send_frame(FRAME_LEN, 1'b0, f[0], $urandom, 1'b1);
            wait_drain();
        end
        rdy_mode = 0;

        // Partial frame aborted by reset: no start may follow.
        sc = starts_seen;
        send_frame(77, 1'b0, 1'b0, 32'h0, 1'b0);
        pulse_reset();
        repeat (8) @(posedge clk);
        #1;
        check("no_start_after_abort", 64'(starts_seen), 64'(sc));
        send_frame(FRAME_LEN, 1'b0, 1'b0, $urandom, 1'b1);
        wait_drain();

        // Reset in the middle of the residue stream.
        enc_delay = 2;
        send_frame(FRAME_LEN, 1'b0, 1'b0, $urandom, 1'b1);
        for (int b = 0; b < 5000 && exp_q.size() >= 100; b++) begin
            @(posedge clk); #1;
        end
        pulse_reset();
        send_frame(FRAME_LEN, 1'b0, 1'b1, $urandom, 1'b1);
        wait_drain();

        // Encoder never responds: expect one err pulse at WAIT cycle TIMEOUT.
        enc_never = 1'b1;
        send_frame(FRAME_LEN, 1'b0, 1'b0, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < TIMEOUT + 50 && !found; i++) begin
            @(negedge clk);
            if (err) found = 1'b1;
        end
        check("err_seen", found, 1'b1);
        check("err_cycle", 64'(cyc - start_cyc), 64'(TIMEOUT));
        @(negedge clk);
        check("err_one_cycle", err, 1'b0);
        check("after_err_in_ready", in_ready, 1'b1);
        check("after_err_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        enc_never = 1'b0;

        // Normal frame after the error path.
        enc_delay = 5; rdy_mode = 2;
        send_frame(FRAME_LEN, 1'b0, 1'b0, $urandom, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
